// File: rtl/cursor_ctrl.sv
// Player-side cursor and command initiator for the minesweeper cover board.
// Debounces six buttons, moves a wrapping cursor with auto-repeat, and issues open/flag commands.
module cursor_ctrl #(
    parameter int x_size       = 16,
    parameter int y_size       = 16,
    parameter int x_coord_bits = 4,
    parameter int y_coord_bits = 4,
    parameter int db_cycles    = 250000,
    parameter int repeat_delay = 25000000,
    parameter int repeat_rate  = 5000000,
    parameter int count_bits   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    btn_up,
    input  logic                    btn_down,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    btn_open,
    input  logic                    btn_flag,
    input  logic                    opened_cell,
    output logic [x_coord_bits-1:0] x_pos,
    output logic [x_coord_bits-1:0] x_coord,
    output logic [y_coord_bits-1:0] y_pos,
    output logic [y_coord_bits-1:0] y_coord,
    output logic                    open,
    output logic                    flag,
    output logic                    busy,
    output logic [count_bits-1:0]   cells_opened
);

    localparam int unsigned NBTN = 6;
    localparam int DB_W    = $clog2(db_cycles);
    localparam int RPT_MAX = (repeat_delay > repeat_rate) ? repeat_delay : repeat_rate;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);
    localparam int CELLS   = x_size * y_size;
    localparam int INIT_W  = $clog2(CELLS + 2);

    localparam logic [x_coord_bits-1:0] X_LAST     = x_coord_bits'(x_size - 1);
    localparam logic [y_coord_bits-1:0] Y_LAST     = y_coord_bits'(y_size - 1);
    localparam logic [DB_W-1:0]         DB_LAST    = DB_W'(db_cycles - 1);
    localparam logic [RPT_W-1:0]        DELAY_LAST = RPT_W'(repeat_delay - 1);
    localparam logic [RPT_W-1:0]        RATE_LAST  = RPT_W'(repeat_rate - 1);
    localparam logic [INIT_W-1:0]       INIT_LAST  = INIT_W'(CELLS + 1);
    localparam logic [count_bits-1:0]   CNT_MAX    = count_bits'(CELLS);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_CMD,
        S_SETTLE
    } state_t;

    // Button order: up, down, left, right, open, flag (bit 0 = highest move priority)
    logic [NBTN-1:0] raw;
    logic [NBTN-1:0] sync1_q, sync2_q;
    logic [NBTN-1:0] db_lvl_q, db_lvl_d, db_prev_q;
    logic [NBTN-1:0] press;
    logic [DB_W-1:0] db_cnt_q [NBTN];
    logic [DB_W-1:0] db_cnt_d [NBTN];

    logic             held_v;
    logic [1:0]       held_dir;
    logic             rpt_v_q, rpt_v_d;
    logic [1:0]       rpt_dir_q, rpt_dir_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_phase_q, rpt_phase_d;
    logic             tick;
    logic [3:0]       rpt_req;
    logic [3:0]       mv;

    state_t                  state_q, state_d;
    logic [INIT_W-1:0]       init_cnt_q, init_cnt_d;
    logic                    settle_q, settle_d;
    logic                    cmd_flag_q, cmd_flag_d;
    logic [x_coord_bits-1:0] x_q, x_d;
    logic [y_coord_bits-1:0] y_q, y_d;
    logic [count_bits-1:0]   cnt_q, cnt_d;

    assign raw = {btn_flag, btn_open, btn_right, btn_left, btn_down, btn_up};

    always_comb begin
        for (int unsigned i = 0; i < NBTN; i++) begin
            db_cnt_d[i] = '0;
            db_lvl_d[i] = db_lvl_q[i];
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press = db_lvl_q & ~db_prev_q;

    always_comb begin
        held_v   = |db_lvl_q[3:0];
        held_dir = 2'd0;
        if (db_lvl_q[0]) begin
            held_dir = 2'd0;
        end else if (db_lvl_q[1]) begin
            held_dir = 2'd1;
        end else if (db_lvl_q[2]) begin
            held_dir = 2'd2;
        end else if (db_lvl_q[3]) begin
            held_dir = 2'd3;
        end
    end

    // Timer restarts whenever the tracked direction appears, vanishes or changes
    always_comb begin
        rpt_v_d     = rpt_v_q;
        rpt_dir_d   = rpt_dir_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_phase_d = rpt_phase_q;
        tick        = 1'b0;
        if (!held_v || !rpt_v_q || held_dir != rpt_dir_q) begin
            rpt_v_d     = held_v;
            rpt_dir_d   = held_dir;
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b0;
        end else if (rpt_cnt_q == (rpt_phase_q ? RATE_LAST : DELAY_LAST)) begin
            tick        = 1'b1;
            rpt_cnt_d   = '0;
            rpt_phase_d = 1'b1;
        end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
        end
    end

    assign rpt_req = tick ? (4'b0001 << rpt_dir_q) : '0;
    assign mv      = press[3:0] | rpt_req;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        settle_d   = settle_q;
        cmd_flag_d = cmd_flag_q;
        x_d        = x_q;
        y_d        = y_q;
        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == INIT_LAST) begin
                    init_cnt_d = '0;
                    state_d    = S_IDLE;
                end
            end
            S_IDLE: begin
                if (press[5]) begin
                    cmd_flag_d = 1'b1;
                    state_d    = S_CMD;
                end else if (press[4]) begin
                    cmd_flag_d = 1'b0;
                    state_d    = S_CMD;
                end else if (mv[0]) begin
                    y_d = (y_q == '0) ? Y_LAST : y_q - 1'b1;
                end else if (mv[1]) begin
                    y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
                end else if (mv[2]) begin
                    x_d = (x_q == '0) ? X_LAST : x_q - 1'b1;
                end else if (mv[3]) begin
                    x_d = (x_q == X_LAST) ? '0 : x_q + 1'b1;
                end
            end
            S_CMD: begin
                settle_d = 1'b0;
                state_d  = S_SETTLE;
            end
            S_SETTLE: begin
                settle_d = 1'b1;
                if (settle_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (opened_cell && state_q != S_INIT && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            db_lvl_q    <= '0;
            db_prev_q   <= '0;
            for (int unsigned i = 0; i < NBTN; i++) begin
                db_cnt_q[i] <= '0;
            end
            rpt_v_q     <= 1'b0;
            rpt_dir_q   <= '0;
            rpt_cnt_q   <= '0;
            rpt_phase_q <= 1'b0;
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            settle_q    <= 1'b0;
            cmd_flag_q  <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
        end else begin
            sync1_q     <= raw;
            sync2_q     <= sync1_q;
            db_lvl_q    <= db_lvl_d;
            db_prev_q   <= db_lvl_q;
            for (int unsigned i = 0; i < NBTN; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
            end
            rpt_v_q     <= rpt_v_d;
            rpt_dir_q   <= rpt_dir_d;
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_phase_q <= rpt_phase_d;
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            settle_q    <= settle_d;
            cmd_flag_q  <= cmd_flag_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
        end
    end

    assign x_pos        = x_q;
    assign x_coord      = x_q;
    assign y_pos        = y_q;
    assign y_coord      = y_q;
    assign open         = (state_q == S_CMD) && !cmd_flag_q;
    assign flag         = (state_q == S_CMD) && cmd_flag_q;
    assign busy         = (state_q != S_IDLE);
    assign cells_opened = cnt_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Randomized scoreboard bench for cursor_ctrl: a timing-aware reference model predicts
// every cursor move and command pulse; a negedge monitor pops and compares them.
module tb_cursor_ctrl;

    localparam int XS    = 16;
    localparam int YS    = 16;
    localparam int DB    = 4;
    localparam int DELAY = 20;
    localparam int RATE  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic btn_open = 1'b0, btn_flag = 1'b0;
    logic opened_cell = 1'b0;
    logic [3:0] x_pos, x_coord, y_pos, y_coord;
    logic       open, flag, busy;
    logic [8:0] cells_opened;

    cursor_ctrl #(
        .x_size(XS), .y_size(YS), .x_coord_bits(4), .y_coord_bits(4),
        .db_cycles(DB), .repeat_delay(DELAY), .repeat_rate(RATE), .count_bits(9)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left), .btn_right(btn_right),
        .btn_open(btn_open), .btn_flag(btn_flag), .opened_cell(opened_cell),
        .x_pos(x_pos), .x_coord(x_coord), .y_pos(y_pos), .y_coord(y_coord),
        .open(open), .flag(flag), .busy(busy), .cells_opened(cells_opened)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;
    int mx = 0, my = 0;

    typedef struct {
        int kind;  // 0 move, 1 open, 2 flag
        int x;
        int y;
        int t;
    } ev_t;
    ev_t evq[$];
    bit  busy_exp[int];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take_ev(input int k);
        ev_t e;
        n_checks++;
        if (evq.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d at (%0d,%0d) cycle %0d, expected none",
                     k, x_pos, y_pos, cyc);
        end else begin
            e = evq.pop_front();
            if (e.kind != k || e.x != int'(x_pos) || e.y != int'(y_pos) || e.t != cyc ||
                x_coord !== x_pos || y_coord !== y_pos) begin
                n_fail++;
                $display("FAIL event: got kind %0d (%0d,%0d) coord (%0d,%0d) cycle %0d, expected kind %0d (%0d,%0d) cycle %0d",
                         k, x_pos, y_pos, x_coord, y_coord, cyc, e.kind, e.x, e.y, e.t);
            end
        end
    endtask

    int px = 0, py = 0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (int'(x_pos) != px || int'(y_pos) != py) take_ev(0);
            if (open === 1'b1) take_ev(1);
            if (flag === 1'b1) take_ev(2);
            chk("busy", int'(busy), busy_exp.exists(cyc) ? 1 : 0);
        end
        px = int'(x_pos);
        py = int'(y_pos);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [5:0] m);
        btn_up    = m[0];
        btn_down  = m[1];
        btn_left  = m[2];
        btn_right = m[3];
        btn_open  = m[4];
        btn_flag  = m[5];
    endtask

    task automatic do_move(input logic [5:0] m, input int t);
        if (m[0])      my = (my + YS - 1) % YS;
        else if (m[1]) my = (my + 1) % YS;
        else if (m[2]) mx = (mx + XS - 1) % XS;
        else           mx = (mx + 1) % XS;
        evq.push_back('{0, mx, my, t});
    endtask

    task automatic push_cmd(input int k, input int t);
        evq.push_back('{k, mx, my, t});
        for (int c = t; c < t + 3; c++) busy_exp[c] = 1'b1;
    endtask

    // Buttons in m held for h cycles from now. The debounced edge lands 2+DB cycles later,
    // its effect one cycle after that; repeats follow at DELAY then every RATE while held.
    task automatic press(input logic [5:0] m, input int h);
        int p, e;
        p = cyc;
        e = p + 2 + DB;
        if (h >= DB) begin
            if (m[5])             push_cmd(2, e + 1);
            else if (m[4])        push_cmd(1, e + 1);
            else if (m[3:0] != 0) do_move(m, e + 1);
            if (m[3:0] != 0)
                for (int t = e + 1 + DELAY; t <= p + h + 2 + DB; t += RATE) do_move(m, t);
        end
        set_btns(m);
        step(h);
        set_btns('0);
        step(DB + 8);
    endtask

    initial begin
        int r0, p, e, h, sel, exp_cnt;
        bit saw_cmd;
        logic [5:0] m, m2;

        step(3);
        chk("rst_x_pos", int'(x_pos), 0);
        chk("rst_y_pos", int'(y_pos), 0);
        chk("rst_open", int'(open), 0);
        chk("rst_flag", int'(flag), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_cells", int'(cells_opened), 0);

        reset = 1'b0;
        r0 = cyc;
        btn_open = 1'b1;
        saw_cmd = 1'b0;
        for (int k = 1; k <= XS * YS + 2; k++) begin
            step(1);
            if (open === 1'b1 || flag === 1'b1) saw_cmd = 1'b1;
            if (k == 100) btn_open = 1'b0;
            if (k >= 40 && k <= 60) opened_cell = logic'(k % 2);
            if (k == XS * YS + 1) begin
                chk("init_busy_last", int'(busy), 1);
                chk("init_cells", int'(cells_opened), 0);
            end
        end
        chk("init_busy_done", int'(busy), 0);
        chk("init_cycles", cyc - r0, XS * YS + 2);
        chk("init_no_cmd", int'(saw_cmd), 0);
        mon_en = 1'b1;

        press(6'b000100, 8);   // left wrap at x=0
        press(6'b000001, 8);   // up wrap at y=0
        press(6'b000010, 8);   // down wrap at y=15
        press(6'b001000, 8);   // right wrap at x=15

        while (mx != 3) press(6'b001000, 6);
        while (my != 5) press(6'b000010, 6);
        press(6'b110000, 8);   // flag wins over open at (3,5)

        // Second press lands in CMD (off=1), SETTLE (2,3) or first IDLE cycle (4)
        for (int j = 0; j < 2; j++) begin
            m2 = (j == 0) ? 6'b010000 : 6'b001000;
            for (int off = 1; off <= 4; off++) begin
                p = cyc;
                e = p + 2 + DB;
                push_cmd(2, e + 1);
                if (off == 4) begin
                    if (m2[4]) push_cmd(1, e + 5);
                    else       do_move(m2, e + 5);
                end
                set_btns(6'b100000);
                step(off);
                set_btns(6'b100000 | m2);
                step(12);
                set_btns('0);
                step(DB + 8);
            end
        end

        press(6'b001000, 50);  // auto-repeat then release

        for (int i = 0; i < 40; i++) begin
            sel = $urandom_range(0, 5);
            h = $urandom_range(DB, 45);
            case (sel)
                0: m = 6'(1 << $urandom_range(0, 3));
                1: m = 6'($urandom_range(1, 15));
                2: m = 6'($urandom_range(1, 3) << 4);
                3: m = 6'(($urandom_range(1, 3) << 4) | (1 << $urandom_range(0, 3)));
                4: begin
                    m = 6'($urandom_range(1, 63));
                    h = $urandom_range(1, DB - 1);
                end
                default: begin
                    m = 6'(1 << $urandom_range(0, 3));
                    h = $urandom_range(40, 70);
                end
            endcase
            press(m, h);
        end

        exp_cnt = 0;
        for (int i = 1; i <= 300; i++) begin
            opened_cell = 1'b1;
            step(1);
            opened_cell = 1'b0;
            exp_cnt = (i < XS * YS) ? i : XS * YS;
            chk("cells_opened", int'(cells_opened), exp_cnt);
            step(1);
        end

        if (mx == 0) press(6'b001000, 6);
        if (my == 0) press(6'b000010, 6);
        p = cyc;
        push_cmd(1, p + DB + 3);
        btn_open = 1'b1;
        step(DB + 4);          // now in SETTLE
        mon_en = 1'b0;
        reset = 1'b1;
        #1;
        chk("midrst_x_pos", int'(x_pos), 0);
        chk("midrst_x_coord", int'(x_coord), 0);
        chk("midrst_y_pos", int'(y_pos), 0);
        chk("midrst_y_coord", int'(y_coord), 0);
        chk("midrst_open", int'(open), 0);
        chk("midrst_flag", int'(flag), 0);
        chk("midrst_busy", int'(busy), 1);
        chk("midrst_cells", int'(cells_opened), 0);
        btn_open = 1'b0;
        step(2);
        chk("queue_empty", evq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
